// File: rtl/tree_walker.sv
// rtl/tree_walker.sv - descends/ascends a static tree image by child identifier with a bounded path stack
module tree_walker #(
  parameter int IDENTIFIER_SIZE     = 8,
  parameter int NODE_ADDR_SIZE      = 8,
  parameter int MAX_NODES_PER_LEVEL = 4,
  parameter int NUM_MSGS            = 16,
  parameter int MAX_DEPTH           = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_MSGS*(IDENTIFIER_SIZE+NODE_ADDR_SIZE*(MAX_NODES_PER_LEVEL+1))-1:0] tree_i,
  input  logic                                  cmd_valid_i,
  output logic                                  cmd_ready_o,
  input  logic [1:0]                            cmd_op_i,
  input  logic [IDENTIFIER_SIZE-1:0]            cmd_id_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [1:0]                            rsp_status_o,
  output logic [NODE_ADDR_SIZE-1:0]             rsp_node_addr_o,
  output logic [$clog2(MAX_DEPTH+1)-1:0]        depth_o
);

  localparam int NODE_SIZE = IDENTIFIER_SIZE + NODE_ADDR_SIZE * (MAX_NODES_PER_LEVEL + 1);
  localparam int DW        = $clog2(MAX_DEPTH + 1);
  localparam int KW        = (MAX_NODES_PER_LEVEL > 1) ? $clog2(MAX_NODES_PER_LEVEL) : 1;

  localparam logic [1:0] OP_DESCEND   = 2'b00;
  localparam logic [1:0] OP_ASCEND    = 2'b01;
  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_NOT_FOUND = 2'b01;
  localparam logic [1:0] ST_OVERFLOW  = 2'b10;
  localparam logic [1:0] ST_UNDERFLOW = 2'b11;

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_e;

  state_e                     state_q, state_d;
  logic                       live_q;
  logic [KW-1:0]              k_q, k_d;
  logic [IDENTIFIER_SIZE-1:0] id_q, id_d;
  logic [1:0]                 status_q, status_d;
  logic [NODE_ADDR_SIZE-1:0]  cur_q, cur_d;
  logic [DW-1:0]              depth_q, depth_d;
  logic [NODE_ADDR_SIZE-1:0]  stack_q [MAX_DEPTH];
  logic [NODE_ADDR_SIZE-1:0]  stack_d [MAX_DEPTH];

  logic [NODE_SIZE-1:0]       cur_node;
  logic [NODE_ADDR_SIZE-1:0]  child_addr;
  logic [IDENTIFIER_SIZE-1:0] child_id;
  logic                       child_in_range;
  logic [NODE_ADDR_SIZE-1:0]  top_addr;
  logic                       child_match;

  // Parent fields ride along in the image but the walker keeps its own path stack instead.
  logic unused_tree;
  assign unused_tree = ^tree_i;

  // Look up the current node, the child in slot k, that child's identifier and the stack top.
  always_comb begin
    cur_node = '0;
    for (int n = 0; n < NUM_MSGS; n++) begin
      if (cur_q == NODE_ADDR_SIZE'(n)) cur_node = tree_i[n*NODE_SIZE +: NODE_SIZE];
    end
    child_addr = '0;
    for (int s = 0; s < MAX_NODES_PER_LEVEL; s++) begin
      if (k_q == KW'(s)) child_addr = cur_node[IDENTIFIER_SIZE + s*NODE_ADDR_SIZE +: NODE_ADDR_SIZE];
    end
    child_id       = '0;
    child_in_range = 1'b0;
    for (int n = 0; n < NUM_MSGS; n++) begin
      if (child_addr == NODE_ADDR_SIZE'(n)) begin
        child_id       = tree_i[n*NODE_SIZE +: IDENTIFIER_SIZE];
        child_in_range = 1'b1;
      end
    end
    top_addr = '0;
    for (int d = 0; d < MAX_DEPTH; d++) begin
      if (depth_q == DW'(d + 1)) top_addr = stack_q[d];
    end
    child_match = (child_addr != '0) && child_in_range && (child_id == id_q);
  end

  // Next-state logic: command decode, one slot per SEARCH cycle, response hold.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    id_d     = id_q;
    status_d = status_q;
    cur_d    = cur_q;
    depth_d  = depth_q;
    for (int d = 0; d < MAX_DEPTH; d++) stack_d[d] = stack_q[d];

    case (state_q)
      IDLE: begin
        if (live_q && cmd_valid_i) begin
          id_d = cmd_id_i;
          k_d  = '0;
          case (cmd_op_i)
            OP_DESCEND: begin
              if (depth_q < DW'(MAX_DEPTH)) begin
                state_d = SEARCH;
              end else begin
                status_d = ST_OVERFLOW;
                state_d  = RESP;
              end
            end
            OP_ASCEND: begin
              if (depth_q != '0) begin
                cur_d    = top_addr;
                depth_d  = depth_q - 1'b1;
                status_d = ST_OK;
              end else begin
                status_d = ST_UNDERFLOW;
              end
              state_d = RESP;
            end
            default: begin
              cur_d    = '0;
              depth_d  = '0;
              for (int d = 0; d < MAX_DEPTH; d++) stack_d[d] = '0;
              status_d = ST_OK;
              state_d  = RESP;
            end
          endcase
        end
      end
      SEARCH: begin
        if (child_match) begin
          for (int d = 0; d < MAX_DEPTH; d++) begin
            if (depth_q == DW'(d)) stack_d[d] = cur_q;
          end
          cur_d    = child_addr;
          depth_d  = depth_q + 1'b1;
          status_d = ST_OK;
          state_d  = RESP;
        end else if ((child_addr == '0) || (k_q == KW'(MAX_NODES_PER_LEVEL - 1))) begin
          status_d = ST_NOT_FOUND;
          state_d  = RESP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, committed position and path stack; live_q holds off cmd_ready_o until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      live_q   <= 1'b0;
      k_q      <= '0;
      id_q     <= '0;
      status_q <= ST_OK;
      cur_q    <= '0;
      depth_q  <= '0;
      for (int d = 0; d < MAX_DEPTH; d++) stack_q[d] <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      k_q      <= k_d;
      id_q     <= id_d;
      status_q <= status_d;
      cur_q    <= cur_d;
      depth_q  <= depth_d;
      for (int d = 0; d < MAX_DEPTH; d++) stack_q[d] <= stack_d[d];
    end
  end

  assign cmd_ready_o     = live_q && (state_q == IDLE);
  assign rsp_valid_o     = (state_q == RESP);
  assign rsp_status_o    = status_q;
  assign rsp_node_addr_o = cur_q;
  assign depth_o         = depth_q;

endmodule

// File: tb/tb_tree_walker.sv
// tb/tb_tree_walker.sv - self-checking bench for tree_walker against a path-stack reference model
module tb_tree_walker;
  localparam int IDW  = 8;
  localparam int AW   = 8;
  localparam int NS   = 4;
  localparam int NM   = 16;
  localparam int MD   = 4;
  localparam int NODE = IDW + AW * (NS + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NM*NODE-1:0] tree;
  logic       cv0, rr0, cv1, rr1;
  logic [1:0] cop0, cop1;
  logic [7:0] cid0, cid1;
  logic       cr0, rv0, cr1, rv1;
  logic [1:0] st0, st1;
  logic [7:0] ad0, ad1;
  logic [2:0] dp0;
  logic [0:0] dp1;

  tree_walker #(.IDENTIFIER_SIZE(IDW), .NODE_ADDR_SIZE(AW), .MAX_NODES_PER_LEVEL(NS),
                .NUM_MSGS(NM), .MAX_DEPTH(MD)) u_dut (
    .clk(clk), .rst_n(rst_n), .tree_i(tree),
    .cmd_valid_i(cv0), .cmd_ready_o(cr0), .cmd_op_i(cop0), .cmd_id_i(cid0),
    .rsp_valid_o(rv0), .rsp_ready_i(rr0), .rsp_status_o(st0),
    .rsp_node_addr_o(ad0), .depth_o(dp0));

  tree_walker #(.IDENTIFIER_SIZE(IDW), .NODE_ADDR_SIZE(AW), .MAX_NODES_PER_LEVEL(NS),
                .NUM_MSGS(NM), .MAX_DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tree_i(tree),
    .cmd_valid_i(cv1), .cmd_ready_o(cr1), .cmd_op_i(cop1), .cmd_id_i(cid1),
    .rsp_valid_o(rv1), .rsp_ready_i(rr1), .rsp_status_o(st1),
    .rsp_node_addr_o(ad1), .depth_o(dp1));

  int checks = 0;
  int errors = 0;

  logic [7:0] t_id  [NM];
  int         t_kid [NM][NS];
  logic [7:0] t_par [NM];

  int m_cur;
  int m_stk[$];

  function automatic logic [NM*NODE-1:0] pack_tree();
    logic [NM*NODE-1:0] v;
    v = '0;
    for (int n = 0; n < NM; n++) begin
      v[n*NODE +: IDW] = t_id[n];
      for (int k = 0; k < NS; k++) v[n*NODE + IDW + k*AW +: AW] = AW'(t_kid[n][k]);
      v[n*NODE + IDW + NS*AW +: AW] = t_par[n];
    end
    return v;
  endfunction

  task automatic set_fixed_tree();
    for (int n = 0; n < NM; n++) begin
      t_id[n] = 8'd0;
      t_par[n] = 8'd0;
      for (int k = 0; k < NS; k++) t_kid[n][k] = 0;
    end
    t_kid[0][0] = 1; t_kid[0][1] = 3;
    t_id[1] = 8'd5; t_kid[1][0] = 2;
    t_id[2] = 8'd7;
    t_id[3] = 8'd9;
    tree = pack_tree();
  endtask

  // Walk semantics from the rules: first-empty-slot stop, out-of-range child never matches.
  task automatic model_cmd(input logic [1:0] op, input logic [7:0] id, output logic [1:0] st, output int lat);
    int c;
    st  = 2'd0;
    lat = 1;
    if (op == 2'b00) begin
      if (m_stk.size() >= MD) st = 2'd2;
      else begin
        st  = 2'd1;
        lat = 2 + NS - 1;
        for (int k = 0; k < NS; k++) begin
          c = t_kid[m_cur][k];
          if (c == 0) begin lat = 2 + k; break; end
          if (c < NM && t_id[c] == id) begin
            st = 2'd0; lat = 2 + k;
            m_stk.push_back(m_cur);
            m_cur = c;
            break;
          end
        end
      end
    end else if (op == 2'b01) begin
      if (m_stk.size() == 0) st = 2'd3;
      else m_cur = m_stk.pop_back();
    end else begin
      m_cur = 0;
      m_stk.delete();
    end
  endtask

  task automatic do_cmd(input int sel, input logic [1:0] op, input logic [7:0] id, input bit auto_ack,
                        output logic [1:0] st, output logic [7:0] ad, output int dp, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!(sel != 0 ? cr1 : cr0) && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: dut%0d never became ready", sel);
    end
    if (sel == 0) begin cv0 = 1'b1; cop0 = op; cid0 = id; end
    else begin cv1 = 1'b1; cop1 = op; cid1 = id; end
    @(posedge clk); #1;
    cv0 = 1'b0; cv1 = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!(sel != 0 ? rv1 : rv0) && lat < 20) begin @(negedge clk); lat++; end
    if (lat >= 20) begin
      checks++; errors++;
      $display("FAIL rsp_valid_timeout: dut%0d op=%0d id=%0d", sel, op, id);
    end
    st = (sel != 0) ? st1 : st0;
    ad = (sel != 0) ? ad1 : ad0;
    dp = (sel != 0) ? int'(dp1) : int'(dp0);
    if (auto_ack) begin
      if (sel == 0) rr0 = 1'b1; else rr1 = 1'b1;
      @(posedge clk); #1;
      rr0 = 1'b0; rr1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cr0 !== 1'b0 || rv0 !== 1'b0 || st0 !== 2'd0 || ad0 !== 8'd0 || dp0 !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b st=%0d addr=%0d depth=%0d expected 0 0 0 0 0", cr0, rv0, st0, ad0, dp0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cr0 !== 1'b0) begin errors++; $display("FAIL reset_ready_early: got %b expected 0", cr0); end
    @(posedge clk); #1;
    checks++;
    if (cr0 !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b expected 1", cr0); end
  endtask

  task automatic test_descend_match();
    logic [1:0] st; logic [7:0] ad; int dp, lat;
    do_cmd(0, 2'b00, 8'd9, 1'b1, st, ad, dp, lat);
    checks++;
    if (st !== 2'd0 || ad !== 8'd3 || dp != 1 || lat != 3) begin
      errors++;
      $display("FAIL descend_match: got st=%0d addr=%0d depth=%0d lat=%0d expected 0 3 1 3", st, ad, dp, lat);
    end
    do_cmd(0, 2'b10, 8'd0, 1'b1, st, ad, dp, lat);
    checks++;
    if (st !== 2'd0 || ad !== 8'd0 || dp != 0 || lat != 1) begin
      errors++;
      $display("FAIL root_cmd: got st=%0d addr=%0d depth=%0d lat=%0d expected 0 0 0 1", st, ad, dp, lat);
    end
  endtask

  task automatic test_path();
    int ops [4] = '{0, 0, 1, 1};
    int ids [4] = '{5, 7, 0, 0};
    int eadr[4] = '{1, 2, 1, 0};
    int edep[4] = '{1, 2, 1, 0};
    int elat[4] = '{2, 2, 1, 1};
    logic [1:0] st; logic [7:0] ad; int dp, lat;
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, 2'(ops[i]), 8'(ids[i]), 1'b1, st, ad, dp, lat);
      checks++;
      if (st !== 2'd0 || ad !== 8'(eadr[i]) || dp != edep[i] || lat != elat[i]) begin
        errors++;
        $display("FAIL path_step%0d: got st=%0d addr=%0d depth=%0d lat=%0d expected 0 %0d %0d %0d",
                 i, st, ad, dp, lat, eadr[i], edep[i], elat[i]);
      end
    end
  endtask

  task automatic test_not_found();
    logic [1:0] st; logic [7:0] ad; int dp, lat;
    do_cmd(0, 2'b00, 8'd4, 1'b1, st, ad, dp, lat);
    checks++;
    if (st !== 2'd1 || ad !== 8'd0 || dp != 0 || lat != 4) begin
      errors++;
      $display("FAIL not_found: got st=%0d addr=%0d depth=%0d lat=%0d expected 1 0 0 4", st, ad, dp, lat);
    end
  endtask

  task automatic test_underflow();
    logic [1:0] st; logic [7:0] ad; int dp, lat;
    do_cmd(0, 2'b01, 8'd0, 1'b1, st, ad, dp, lat);
    checks++;
    if (st !== 2'd3 || ad !== 8'd0 || dp != 0 || lat != 1) begin
      errors++;
      $display("FAIL underflow: got st=%0d addr=%0d depth=%0d lat=%0d expected 3 0 0 1", st, ad, dp, lat);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] st; logic [7:0] ad; int dp, lat;
    do_cmd(1, 2'b00, 8'd5, 1'b1, st, ad, dp, lat);
    checks++;
    if (st !== 2'd0 || ad !== 8'd1 || dp != 1 || lat != 2) begin
      errors++;
      $display("FAIL overflow_first: got st=%0d addr=%0d depth=%0d lat=%0d expected 0 1 1 2", st, ad, dp, lat);
    end
    do_cmd(1, 2'b00, 8'd7, 1'b1, st, ad, dp, lat);
    checks++;
    if (st !== 2'd2 || ad !== 8'd1 || dp != 1 || lat != 1) begin
      errors++;
      $display("FAIL overflow_second: got st=%0d addr=%0d depth=%0d lat=%0d expected 2 1 1 1", st, ad, dp, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] st; logic [7:0] ad; int dp, lat;
    do_cmd(0, 2'b00, 8'd9, 1'b0, st, ad, dp, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rv0 !== 1'b1 || cr0 !== 1'b0 || st0 !== 2'd0 || ad0 !== 8'd3 || dp0 !== 3'd1) begin
        errors++;
        $display("FAIL hold_cycle%0d: got vld=%b rdy=%b st=%0d addr=%0d depth=%0d expected 1 0 0 3 1",
                 i, rv0, cr0, st0, ad0, dp0);
      end
    end
    @(negedge clk);
    rr0 = 1'b1;
    @(posedge clk); #1;
    rr0 = 1'b0;
    checks++;
    if (cr0 !== 1'b1 || rv0 !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got rdy=%b vld=%b expected 1 0", cr0, rv0);
    end
    do_cmd(0, 2'b11, 8'd0, 1'b1, st, ad, dp, lat);
    checks++;
    if (st !== 2'd0 || ad !== 8'd0 || dp != 0 || lat != 1) begin
      errors++;
      $display("FAIL reserved_as_root: got st=%0d addr=%0d depth=%0d lat=%0d expected 0 0 0 1", st, ad, dp, lat);
    end
  endtask

  task automatic test_reset_mid_search();
    logic [1:0] st; logic [7:0] ad; int dp, lat;
    bit seen;
    do_cmd(0, 2'b00, 8'd5, 1'b1, st, ad, dp, lat);
    @(negedge clk);
    cv0 = 1'b1; cop0 = 2'b00; cid0 = 8'd9;
    @(posedge clk); #1;
    cv0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rv0 !== 1'b0 || cr0 !== 1'b0 || ad0 !== 8'd0 || dp0 !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_search: got vld=%b rdy=%b addr=%0d depth=%0d expected 0 0 0 0", rv0, cr0, ad0, dp0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cr0 !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b expected 1", cr0); end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (rv0 !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_mid_no_rsp: got a response expected none"); end
  endtask

  task automatic test_random();
    logic [1:0] st, est, op; logic [7:0] ad, id; int dp, lat, elat, nk, r, c;
    for (int n = 0; n < NM; n++) begin
      t_id[n]  = 8'($urandom_range(0, 7));
      t_par[n] = 8'($urandom_range(0, 255));
      nk = $urandom_range(0, NS);
      for (int k = 0; k < NS; k++) t_kid[n][k] = (k < nk) ? int'($urandom_range(1, NM + 3)) : 0;
    end
    tree = pack_tree();
    do_cmd(0, 2'b10, 8'd0, 1'b1, st, ad, dp, lat);
    m_cur = 0;
    m_stk.delete();
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 7);
      op = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
      c  = t_kid[m_cur][$urandom_range(0, NS - 1)];
      id = ($urandom_range(0, 1) != 0 && c > 0 && c < NM) ? t_id[c] : 8'($urandom_range(0, 7));
      do_cmd(0, op, id, 1'b1, st, ad, dp, lat);
      model_cmd(op, id, est, elat);
      checks++;
      if (st !== est || ad !== 8'(m_cur) || dp != m_stk.size() || lat != elat) begin
        errors++;
        $display("FAIL random%0d op=%0d id=%0d: got st=%0d addr=%0d depth=%0d lat=%0d expected %0d %0d %0d %0d",
                 i, op, id, st, ad, dp, lat, est, m_cur, m_stk.size(), elat);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cv0 = 1'b0; rr0 = 1'b0; cop0 = 2'b00; cid0 = 8'd0;
    cv1 = 1'b0; rr1 = 1'b0; cop1 = 2'b00; cid1 = 8'd0;
    set_fixed_tree();
    test_reset();
    test_descend_match();
    test_path();
    test_not_found();
    test_underflow();
    test_overflow();
    test_backpressure();
    test_reset_mid_search();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
